// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RISC-V datapath: sequences fetch/decode/execute/
// memory/writeback, drives ALU control and mux selects, and traps on illegal encodings.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0,
    parameter logic [3:0] TRAP_STATE  = 4'd11
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       trap
);

    typedef enum logic [3:0] {
        FETCH    = RESET_STATE,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = TRAP_STATE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_FUNCT
    } alu_op_t;

    localparam logic [6:0] OPC_LW  = 7'b0000011;
    localparam logic [6:0] OPC_SW  = 7'b0100011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;

    state_t  state, state_next;
    alu_op_t alu_op;
    logic    alu_f3_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100)
                 || (funct3 == 3'b110) || (funct3 == 3'b111);
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (op)
                    OPC_LW, OPC_SW: state_next = (funct3 == 3'b010) ? MEMADR : TRAP;
                    OPC_R:          state_next = alu_f3_ok ? EXECR : TRAP;
                    OPC_I:          state_next = alu_f3_ok ? EXECI : TRAP;
                    OPC_BEQ:        state_next = (funct3 == 3'b000) ? BEQ : TRAP;
                    OPC_JAL:        state_next = JAL;
                    default:        state_next = TRAP;
                endcase
            end
            MEMADR:   state_next = (op == OPC_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = FETCH;
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            JAL:      state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BEQ:      state_next = FETCH;
            TRAP:     state_next = TRAP;
            default:  state_next = TRAP;
        endcase
    end

    // Outputs are gated by rst_n so an asynchronous reset kills strobes before the next edge.
    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_control = 3'b000;
        trap        = 1'b0;
        alu_op      = OP_ADD;

        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = OP_FUNCT;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = OP_FUNCT;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = OP_SUB;
                pc_write  = zero;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            TRAP:     trap = 1'b1;
            default:  trap = 1'b1;
        endcase

        case (alu_op)
            OP_SUB:   alu_control = 3'b001;
            OP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b100:  alu_control = 3'b100;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default:  alu_control = 3'b000;
        endcase

        case (op)
            OPC_SW:  imm_src = 2'b01;
            OPC_BEQ: imm_src = 2'b10;
            OPC_JAL: imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase

        if (!rst_n) begin
            pc_write    = 1'b0;
            adr_src     = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_write   = 1'b0;
            result_src  = 2'b00;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            imm_src     = 2'b00;
            alu_control = 3'b000;
            trap        = 1'b0;
        end
    end

endmodule
